apb3_cmd_master: RTL and testbench
==================================

# apb3_cmd_master

APB3 initiator that converts a single-outstanding valid/ready command stream into APB3 SETUP/ACCESS transfers and returns each completion as a registered response beat. It is the master-side counterpart of the APB3 slave register blocks. It sits in the system clock domain and drives user APB3 slaves directly, for DMA-style register sequencing without the CPU. Exactly one transfer is in flight at a time.

## Interface

Parameters:
- ADDR_WIDTH, 16, width of PADDR and cmd_addr.
- TIMEOUT_CYCLES, 256, number of ACCESS-phase wait cycles before abort. Legal range 1..65535. Used only when the timeout feature is compiled in.

Ports:
- io_systemClk  in  1  single clock; all logic is rising-edge.
- io_systemReset  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  PRDATA on a successful read; 0 for writes and for timeouts.
- rsp_error  out  1  PSLVERROR sampled at completion, or timeout.
- rsp_timeout  out  1  transfer aborted by the watchdog.
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PREADY  in  1  slave ready.
- PRDATA  in  32  slave read data.
- PSLVERROR  in  1  slave error.
- txn_count  out  16  completed transfers, including errors and timeouts; wraps 0xFFFF -> 0.

## Operation

- FSM states:
  - IDLE: cmd_ready=1. A handshake captures cmd_* into PADDR/PWRITE/PWDATA; next state SETUP.
  - SETUP: PSEL=1, PENABLE=0. Unconditionally -> ACCESS.
  - ACCESS: PSEL=1, PENABLE=1.
    - PREADY=1: capture rsp_rdata (PRDATA when read, else 0) and rsp_error=PSLVERROR. Drop PSEL and PENABLE. Increment txn_count. Next state RESP.
    - PREADY=0: wait; wait counter increments.
  - RESP: rsp_valid=1. On rsp_ready -> IDLE.
- cmd_ready is 0 in SETUP, ACCESS and RESP. Commands are never dropped; the upstream holds them.
- PADDR, PWRITE and PWDATA are registered, stable from SETUP through ACCESS, and retain their last value in IDLE and RESP.
- PSLVERROR and PRDATA are ignored when PREADY=0.
- rsp_* fields are stable while rsp_valid=1 and rsp_ready=0.

## Timing

- All outputs are registered.
- Reset values:
  - cmd_ready=0 in the reset cycle; 1 from the first cycle after reset deassertion.
  - All other outputs 0; state IDLE; wait counter 0; txn_count 0.
- Zero-wait transfer: handshake at edge T; SETUP in cycle T+1; ACCESS in T+2 with PREADY=1; rsp_valid=1 in T+3.
- N wait states add N cycles.
- Throughput with rsp_ready tied high: one transfer per 4 cycles (IDLE, SETUP, ACCESS, RESP).
- Reset asserted in any state, including mid-ACCESS: on the next edge PSEL=PENABLE=0, rsp_valid=0, any pending response is discarded, and state returns to IDLE.
- Simultaneous rsp_ready and cmd_valid in RESP: the response retires; the command waits for IDLE on the next cycle.

## Configuration

- APB3_CMD_MASTER_TIMEOUT_EN defined:
  - A 16-bit wait counter counts ACCESS cycles with PREADY=0.
  - When it reaches TIMEOUT_CYCLES: PSEL and PENABLE drop on the next edge; RESP with rsp_timeout=1, rsp_error=1, rsp_rdata=0; txn_count increments.
  - The counter clears on entering SETUP.
- Undefined:
  - No counter is instantiated; ACCESS waits indefinitely for PREADY.
  - rsp_timeout is tied to 0.

## Test plan

- Write, zero wait: cmd_write=1, addr=0x0010, wdata=0xDEADBEEF. Requires PSEL at T+1, PENABLE at T+2, PWDATA=0xDEADBEEF throughout, rsp_valid at T+3, rsp_error=0, txn_count=1.
- Read, 3 wait states: PRDATA=0x12345678 at PREADY. Requires rsp_rdata=0x12345678, rsp_valid at T+6, and PADDR stable for all ACCESS cycles.
- Slave error: PSLVERROR=1 with PREADY on a read. Requires rsp_error=1, rsp_timeout=0.
- Timeout, macro defined, TIMEOUT_CYCLES=16, PREADY held 0: PSEL drops after 16 ACCESS wait cycles; response has rsp_timeout=1, rsp_error=1, rsp_rdata=0. With the macro undefined, the transfer is still in ACCESS after 1000 cycles.
- Response backpressure: rsp_ready low for 5 cycles with cmd_valid high. Requires rsp fields stable, cmd_ready=0 throughout, and the next SETUP 2 cycles after rsp_ready rises.
- Reset mid-ACCESS: assert io_systemReset. Requires all outputs 0 on the next edge, txn_count=0, and a clean transfer completing afterwards.

Source files
------------

// File: rtl/apb3_cmd_master_if.sv
// Command/response stream and APB3 bus bundle for apb3_cmd_master.
// The master modport is the initiator's view; slave is the environment (command source + APB slave).
interface apb3_cmd_master_if #(
   parameter int ADDR_WIDTH = 16
) ();
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [31:0]           cmd_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_rdata;
   logic                  rsp_error;
   logic                  rsp_timeout;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [31:0]           PWDATA;
   logic                  PREADY;
   logic [31:0]           PRDATA;
   logic                  PSLVERROR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  PREADY, PRDATA, PSLVERROR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output PREADY, PRDATA, PSLVERROR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
   );
endinterface

// File: rtl/apb3_cmd_master.sv
// Single-outstanding command stream to APB3 initiator with registered response beat.
// Optional ACCESS-phase watchdog enabled by defining APB3_CMD_MASTER_TIMEOUT_EN.
module apb3_cmd_master #(
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic               io_systemClk,
   input  logic               io_systemReset,
   apb3_cmd_master_if.master  bus,
   output logic [15:0]        txn_count
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t                state_reg;
   logic                  cmd_ready_reg;
   logic                  psel_reg;
   logic                  penable_reg;
   logic [ADDR_WIDTH-1:0] paddr_reg;
   logic                  pwrite_reg;
   logic [31:0]           pwdata_reg;
   logic                  rsp_valid_reg;
   logic [31:0]           rsp_rdata_reg;
   logic                  rsp_error_reg;
   logic [15:0]           txn_count_reg;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("apb3_cmd_master: TIMEOUT_CYCLES must be in 1..65535");
   end

`ifdef APB3_CMD_MASTER_TIMEOUT_EN
   logic        rsp_timeout_reg;
   logic [15:0] wait_cnt_reg;
   assign bus.rsp_timeout = rsp_timeout_reg;
`else
   assign bus.rsp_timeout = 1'b0;
`endif

   always_ff @(posedge io_systemClk) begin
      if (io_systemReset) begin
         state_reg     <= IDLE;
         cmd_ready_reg <= 1'b0;
         psel_reg      <= 1'b0;
         penable_reg   <= 1'b0;
         paddr_reg     <= '0;
         pwrite_reg    <= 1'b0;
         pwdata_reg    <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= '0;
         rsp_error_reg <= 1'b0;
         txn_count_reg <= '0;
`ifdef APB3_CMD_MASTER_TIMEOUT_EN
         rsp_timeout_reg <= 1'b0;
         wait_cnt_reg    <= '0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               // cmd_ready rises one cycle after reset release, so the handshake keys off the register
               cmd_ready_reg <= 1'b1;
               if (cmd_ready_reg && bus.cmd_valid) begin
                  cmd_ready_reg <= 1'b0;
                  paddr_reg     <= bus.cmd_addr;
                  pwrite_reg    <= bus.cmd_write;
                  pwdata_reg    <= bus.cmd_wdata;
                  psel_reg      <= 1'b1;
                  state_reg     <= SETUP;
`ifdef APB3_CMD_MASTER_TIMEOUT_EN
                  wait_cnt_reg  <= '0;
`endif
               end
            end
            SETUP: begin
               penable_reg <= 1'b1;
               state_reg   <= ACCESS;
            end
            ACCESS: begin
               if (bus.PREADY) begin
                  psel_reg      <= 1'b0;
                  penable_reg   <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  rsp_rdata_reg <= pwrite_reg ? 32'd0 : bus.PRDATA;
                  rsp_error_reg <= bus.PSLVERROR;
                  txn_count_reg <= txn_count_reg + 16'd1;
                  state_reg     <= RESP;
`ifdef APB3_CMD_MASTER_TIMEOUT_EN
                  rsp_timeout_reg <= 1'b0;
               end else if (wait_cnt_reg == 16'(TIMEOUT_CYCLES - 1)) begin
                  // This edge closes the TIMEOUT_CYCLES-th stalled ACCESS cycle
                  psel_reg        <= 1'b0;
                  penable_reg     <= 1'b0;
                  rsp_valid_reg   <= 1'b1;
                  rsp_rdata_reg   <= '0;
                  rsp_error_reg   <= 1'b1;
                  rsp_timeout_reg <= 1'b1;
                  txn_count_reg   <= txn_count_reg + 16'd1;
                  state_reg       <= RESP;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 16'd1;
`endif
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  cmd_ready_reg <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = cmd_ready_reg;
   assign bus.PSEL      = psel_reg;
   assign bus.PENABLE   = penable_reg;
   assign bus.PADDR     = paddr_reg;
   assign bus.PWRITE    = pwrite_reg;
   assign bus.PWDATA    = pwdata_reg;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_rdata = rsp_rdata_reg;
   assign bus.rsp_error = rsp_error_reg;
   assign txn_count     = txn_count_reg;
endmodule

// File: tb/tb_apb3_cmd_master.sv
// Directed self-checking bench for apb3_cmd_master; one task per scenario.
// Works with or without APB3_CMD_MASTER_TIMEOUT_EN (timeout scenario adapts).
module tb_apb3_cmd_master;
   logic        clk;
   logic        srst;
   logic [15:0] txn_count;
   int          checks;
   int          errors;
   logic [15:0] exp_txn;

   apb3_cmd_master_if #(.ADDR_WIDTH(16)) bus ();

   apb3_cmd_master #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
      .io_systemClk   (clk),
      .io_systemReset (srst),
      .bus            (bus),
      .txn_count      (txn_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0; bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERROR = 1'b0;
   endtask

   task automatic test_reset();
      srst = 1'b1;
      idle_inputs();
      tick(); tick();
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 0", bus.cmd_ready); end
      checks++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) begin errors++; $display("FAIL rst_psel_penable: got %b%b expected 00", bus.PSEL, bus.PENABLE); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); end
      checks++; if (txn_count !== 16'd0) begin errors++; $display("FAIL rst_txn: got %0d expected 0", txn_count); end
      srst = 1'b0;
      exp_txn = 16'd0;
      tick();
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_cmd_ready: got %b expected 1", bus.cmd_ready); end
      $display("test_reset done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_write_zero_wait();
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 16'h0010; bus.cmd_wdata = 32'hDEADBEEF;
      bus.PREADY = 1'b1;
      tick();  // handshake edge T
      bus.cmd_valid = 1'b0; bus.cmd_wdata = 32'h0;
      checks++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0) begin errors++; $display("FAIL wr_setup: got psel=%b pen=%b expected 1 0", bus.PSEL, bus.PENABLE); end
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_setup_cmd_ready: got %b expected 0", bus.cmd_ready); end
      checks++; if (bus.PADDR !== 16'h0010 || bus.PWRITE !== 1'b1 || bus.PWDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_setup_bus: got %h %b %h expected 0010 1 deadbeef", bus.PADDR, bus.PWRITE, bus.PWDATA); end
      tick();  // T+2 ACCESS
      checks++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1) begin errors++; $display("FAIL wr_access: got psel=%b pen=%b expected 1 1", bus.PSEL, bus.PENABLE); end
      checks++; if (bus.PWDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_access_pwdata: got %h expected deadbeef", bus.PWDATA); end
      tick();  // T+3 RESP
      exp_txn = exp_txn + 16'd1;
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid: got %b expected 1", bus.rsp_valid); end
      checks++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) begin errors++; $display("FAIL wr_rsp_psel: got %b%b expected 00", bus.PSEL, bus.PENABLE); end
      checks++; if (bus.rsp_error !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL wr_rsp_fields: got err=%b rdata=%h to=%b expected 0 0 0", bus.rsp_error, bus.rsp_rdata, bus.rsp_timeout); end
      checks++; if (txn_count !== exp_txn) begin errors++; $display("FAIL wr_txn: got %0d expected %0d", txn_count, exp_txn); end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_retire: got rv=%b cr=%b expected 0 1", bus.rsp_valid, bus.cmd_ready); end
      $display("test_write_zero_wait done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_read_wait3();
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0124;
      // Junk on PRDATA/PSLVERROR while PREADY is low must be ignored
      bus.PREADY = 1'b0; bus.PRDATA = 32'hBAD0BAD0; bus.PSLVERROR = 1'b1;
      tick();  // T
      bus.cmd_valid = 1'b0; bus.cmd_addr = 16'hFFFF;
      checks++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0 || bus.PWRITE !== 1'b0) begin errors++; $display("FAIL rd_setup: got psel=%b pen=%b pw=%b expected 1 0 0", bus.PSEL, bus.PENABLE, bus.PWRITE); end
      for (int i = 0; i < 4; i++) begin  // ACCESS cycles T+2..T+5
         tick();
         checks++; if (bus.PENABLE !== 1'b1 || bus.PSEL !== 1'b1 || bus.PADDR !== 16'h0124 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_access_%0d: got psel=%b pen=%b addr=%h rv=%b expected 1 1 0124 0", i, bus.PSEL, bus.PENABLE, bus.PADDR, bus.rsp_valid); end
      end
      bus.PREADY = 1'b1; bus.PRDATA = 32'h12345678; bus.PSLVERROR = 1'b0;
      tick();  // T+6
      exp_txn = exp_txn + 16'd1;
      bus.PRDATA = 32'h0;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_rsp: got rv=%b rdata=%h expected 1 12345678", bus.rsp_valid, bus.rsp_rdata); end
      checks++; if (bus.rsp_error !== 1'b0 || txn_count !== exp_txn) begin errors++; $display("FAIL rd_rsp_err_txn: got err=%b txn=%0d expected 0 %0d", bus.rsp_error, txn_count, exp_txn); end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      $display("test_read_wait3 done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_slave_error();
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0040;
      bus.PREADY = 1'b1; bus.PRDATA = 32'hCAFEF00D; bus.PSLVERROR = 1'b1;
      tick(); bus.cmd_valid = 1'b0;
      tick(); tick();
      exp_txn = exp_txn + 16'd1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1 || bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL slverr_rsp: got rv=%b err=%b to=%b expected 1 1 0", bus.rsp_valid, bus.rsp_error, bus.rsp_timeout); end
      checks++; if (txn_count !== exp_txn) begin errors++; $display("FAIL slverr_txn: got %0d expected %0d", txn_count, exp_txn); end
      bus.PSLVERROR = 1'b0;
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      $display("test_slave_error done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_backpressure();
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 16'h0200; bus.cmd_wdata = 32'h000055AA;
      bus.PREADY = 1'b1;
      tick();
      // Next command stays offered for the whole response stall
      bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0300;
      tick(); tick();
      exp_txn = exp_txn + 16'd1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.rsp_error !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.PSEL !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d: got rv=%b rdata=%h err=%b cr=%b psel=%b expected 1 0 0 0 0", i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.cmd_ready, bus.PSEL); end
         if (i < 4) tick();
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.PSEL !== 1'b0) begin errors++; $display("FAIL bp_idle: got rv=%b cr=%b psel=%b expected 0 1 0", bus.rsp_valid, bus.cmd_ready, bus.PSEL); end
      tick();
      bus.cmd_valid = 1'b0;
      checks++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0 || bus.PADDR !== 16'h0300 || bus.PWRITE !== 1'b0) begin errors++; $display("FAIL bp_next_setup: got psel=%b pen=%b addr=%h pw=%b expected 1 0 0300 0", bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE); end
      bus.PRDATA = 32'h0BADF00D;
      tick(); tick();
      exp_txn = exp_txn + 16'd1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0BADF00D || txn_count !== exp_txn) begin errors++; $display("FAIL bp_next_rsp: got rv=%b rdata=%h txn=%0d expected 1 0badf00d %0d", bus.rsp_valid, bus.rsp_rdata, txn_count, exp_txn); end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0; bus.PRDATA = 32'h0;
      $display("test_backpressure done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_timeout();
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0500;
      bus.PREADY = 1'b0; bus.PRDATA = 32'h77777777;
      tick(); bus.cmd_valid = 1'b0;
`ifdef APB3_CMD_MASTER_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1) begin errors++; $display("FAIL to_wait_%0d: got psel=%b pen=%b expected 1 1", i, bus.PSEL, bus.PENABLE); end
      end
      tick();
      exp_txn = exp_txn + 16'd1;
      checks++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL to_abort: got psel=%b pen=%b rv=%b expected 0 0 1", bus.PSEL, bus.PENABLE, bus.rsp_valid); end
      checks++; if (bus.rsp_timeout !== 1'b1 || bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_rsp: got to=%b err=%b rdata=%h expected 1 1 0", bus.rsp_timeout, bus.rsp_error, bus.rsp_rdata); end
      checks++; if (txn_count !== exp_txn) begin errors++; $display("FAIL to_txn: got %0d expected %0d", txn_count, exp_txn); end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
`else
      for (int i = 0; i < 1000; i++) tick();
      checks++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL hang_still_access: got psel=%b pen=%b rv=%b to=%b expected 1 1 0 0", bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.rsp_timeout); end
      checks++; if (txn_count !== exp_txn) begin errors++; $display("FAIL hang_txn: got %0d expected %0d", txn_count, exp_txn); end
`endif
      bus.PRDATA = 32'h0;
      $display("test_timeout done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_reset_mid_access();
      bus.PREADY = 1'b0;
      if (bus.PSEL !== 1'b1) begin
         bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 16'h0600; bus.cmd_wdata = 32'h11112222;
         tick(); bus.cmd_valid = 1'b0;
         tick(); tick();
      end
      checks++; if (bus.PENABLE !== 1'b1) begin errors++; $display("FAIL rma_pre_access: got pen=%b expected 1", bus.PENABLE); end
      srst = 1'b1;
      tick();
      exp_txn = 16'd0;
      checks++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rma_ctrl: got psel=%b pen=%b rv=%b cr=%b expected 0 0 0 0", bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready); end
      checks++; if (bus.PADDR !== 16'h0 || bus.PWRITE !== 1'b0 || bus.PWDATA !== 32'h0 || bus.rsp_rdata !== 32'h0 || bus.rsp_error !== 1'b0 || bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL rma_data: got addr=%h pw=%b wd=%h rd=%h err=%b to=%b expected all 0", bus.PADDR, bus.PWRITE, bus.PWDATA, bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout); end
      checks++; if (txn_count !== 16'd0) begin errors++; $display("FAIL rma_txn: got %0d expected 0", txn_count); end
      srst = 1'b0;
      tick();
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 16'h0700; bus.cmd_wdata = 32'hA5A5A5A5;
      bus.PREADY = 1'b1;
      tick(); bus.cmd_valid = 1'b0;
      tick(); tick();
      exp_txn = exp_txn + 16'd1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b0 || txn_count !== exp_txn) begin errors++; $display("FAIL rma_clean_txn: got rv=%b err=%b txn=%0d expected 1 0 %0d", bus.rsp_valid, bus.rsp_error, txn_count, exp_txn); end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      $display("test_reset_mid_access done: checks=%0d errors=%0d", checks, errors);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_txn = 16'd0;
      test_reset();
      test_write_zero_wait();
      test_read_wait3();
      test_slave_error();
      test_backpressure();
      test_timeout();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
